// File: rtl/spi_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_sequencer
// Description : Transaction sequencer for the ILI9341 SPI byte shifter.
//               Accepts command/data bytes over valid/ready, drives the
//               shifter's load/shift-enable/dc/cs inputs, gates SCK and
//               frames multi-byte bursts under a single CS-low window.
//               One MOSI bit per clk cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_sequencer #(
  parameter int DW      = 8,  // bits per SPI byte (>= 2), matches the shifter
  parameter int CS_HOLD = 2   // min CS-high cycles after a burst (>= 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_byte,
  input  logic          i_dc,
  input  logic          i_last,
  output logic          o_ready,
  output logic          o_load,
  output logic          o_shift_en,
  output logic [DW-1:0] o_data,
  output logic          o_dc,
  output logic          o_cs,
  output logic          o_sck_en,
  output logic          o_busy,
  output logic          o_done
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int HW = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_PEN   = CW'(DW - 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD);
  localparam logic [HW-1:0] HOLD_PEN  = HW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_CLOSE = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            last_q;
  logic            accept;

  // A byte is taken whenever the requester offers and we advertise ready.
  assign accept = i_valid & o_ready;

  // Sequencer FSM; every output is registered so the shifter sees clean levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      last_q     <= 1'b0;
      o_ready    <= 1'b0;
      o_load     <= 1'b0;
      o_shift_en <= 1'b0;
      o_data     <= '1;
      o_dc       <= 1'b1;
      o_cs       <= 1'b1;
      o_sck_en   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      // SCK is gated one cycle behind shift-enable so pulses line up with MOSI bits.
      o_sck_en   <= o_shift_en;
      o_load     <= 1'b0;
      o_shift_en <= 1'b0;
      o_done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            o_data  <= i_byte;
            o_dc    <= i_dc;
            o_cs    <= 1'b0;
            last_q  <= i_last;
            o_load  <= 1'b1;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            state   <= S_LOAD;
          end else begin
            o_ready <= 1'b1;
          end
        end

        S_LOAD: begin
          bit_cnt    <= '0;
          o_shift_en <= 1'b1;
          state      <= S_SHIFT;
        end

        S_SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) begin
            if (last_q) begin
              // Reload the shifter with all-ones so MOSI idles high while CS rises.
              o_data  <= '1;
              o_dc    <= 1'b1;
              o_cs    <= 1'b1;
              o_load  <= 1'b1;
              o_ready <= 1'b0;
              state   <= S_CLOSE;
            end else if (accept) begin
              o_data  <= i_byte;
              o_dc    <= i_dc;
              last_q  <= i_last;
              o_load  <= 1'b1;
              o_ready <= 1'b0;
              state   <= S_LOAD;
            end else begin
              // Underrun: keep CS low and ready high until the next byte shows up.
              state   <= S_WAIT;
            end
          end else begin
            o_shift_en <= 1'b1;
            // Ready is raised one cycle early so it is visible in the final bit cycle.
            if (bit_cnt == CNT_PEN) begin
              o_ready <= ~last_q;
            end
          end
        end

        S_WAIT: begin
          if (accept) begin
            o_data  <= i_byte;
            o_dc    <= i_dc;
            last_q  <= i_last;
            o_load  <= 1'b1;
            o_ready <= 1'b0;
            state   <= S_LOAD;
          end
        end

        S_CLOSE: begin
          hold_cnt <= '0;
          state    <= S_HOLD;
        end

        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_PEN) begin
            o_done <= 1'b1;
          end
          if (hold_cnt == HOLD_LAST) begin
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
